// File: rtl/t05_sram_arbiter.sv
// ---------------------------------------------------------------------------
// t05_sram_arbiter
// Round-robin arbiter that shares one SRAM port among three requesters
// (0 = hTree, 1 = FLV, 2 = codebook). The winner's command is latched and
// held on the SRAM side until the wrapper acknowledges it or a timeout
// expires. Every output is a register.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req/wen      : per-requester request and write-enable (3 bits each)
//   addr/wdata   : per-requester address / write data, slice i = requester i
//   gnt          : one-hot grant, high while the requester owns the port
//   done         : one-cycle one-hot completion pulse
//   rdata        : captured read data, valid with done
//   sram_*       : strobe, direction, address, write data toward SRAM;
//                  read data and one-cycle ack from SRAM
//   err          : sticky timeout flag
// ---------------------------------------------------------------------------
module t05_sram_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 71,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            wen,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  sram_en,
    output logic                  sram_wen,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    input  logic                  sram_ack,
    output logic                  err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t              state, state_n;
    logic [1:0]          ptr, ptr_n;
    logic [1:0]          win, win_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2:0]          gnt_n, done_n;
    logic [DATA_W-1:0]   rdata_n;
    logic                sram_en_n, sram_wen_n, err_n;
    logic [ADDR_W-1:0]   sram_addr_n;
    logic [DATA_W-1:0]   sram_wdata_n;
    logic [1:0]          pick_w;

    // Requester index p+i, wrapped modulo 3.
    function automatic logic [1:0] rot(input logic [1:0] p, input int i);
        int s;
        s = (int'(p) + i) % 3;
        return 2'(s);
    endfunction

    // First asserted request scanning ptr, ptr+1, ptr+2. The scan runs from
    // lowest priority upward so the highest-priority hit is written last.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int i = 2; i >= 0; i--) begin
            idx = rot(p, i);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] w);
        return 3'b001 << w;
    endfunction

    assign pick_w = pick(req, ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            done       <= '0;
            rdata      <= '0;
            sram_en    <= 1'b0;
            sram_wen   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            win        <= win_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            done       <= done_n;
            rdata      <= rdata_n;
            sram_en    <= sram_en_n;
            sram_wen   <= sram_wen_n;
            sram_addr  <= sram_addr_n;
            sram_wdata <= sram_wdata_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        win_n        = win;
        cnt_n        = cnt;
        gnt_n        = gnt;
        done_n       = '0;
        rdata_n      = rdata;
        sram_en_n    = sram_en;
        sram_wen_n   = sram_wen;
        sram_addr_n  = sram_addr;
        sram_wdata_n = sram_wdata;
        err_n        = err;

        case (state)
            IDLE: begin
                gnt_n     = '0;
                sram_en_n = 1'b0;
                if (|req) begin
                    win_n        = pick_w;
                    gnt_n        = onehot(pick_w);
                    sram_en_n    = 1'b1;
                    sram_wen_n   = wen[pick_w];
                    sram_addr_n  = addr[pick_w*ADDR_W +: ADDR_W];
                    sram_wdata_n = wdata[pick_w*DATA_W +: DATA_W];
                    cnt_n        = '0;
                    state_n      = BUSY;
                end
            end
            BUSY: begin
                // Ack has priority over a timeout landing in the same cycle.
                // A timeout also advances the pointer so a dead requester
                // cannot starve the others.
                if (sram_ack || cnt == CNT_W'(TIMEOUT - 1)) begin
                    done_n    = onehot(win);
                    gnt_n     = '0;
                    sram_en_n = 1'b0;
                    ptr_n     = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    state_n   = RELEASE;
                    if (sram_ack) begin
                        if (!sram_wen) rdata_n = sram_rdata;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                gnt_n     = '0;
                sram_en_n = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
module tb_t05_sram_arbiter;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 71;
    localparam int TIMEOUT = 255;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [2:0]            req, wen;
    logic [3*ADDR_W-1:0]   addr;
    logic [3*DATA_W-1:0]   wdata;
    logic [2:0]            gnt, done;
    logic [DATA_W-1:0]     rdata;
    logic                  sram_en, sram_wen;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;
    logic                  sram_ack;
    logic                  err;

    int passed = 0;
    int total  = 0;

    t05_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ack(sram_ack), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns so outputs can be sampled
    // and inputs changed well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; wen = '0; addr = '0; wdata = '0;
        sram_rdata = '0; sram_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (gnt !== 3'b000) $display("FAIL reset_gnt got=%b exp=000", gnt); else passed++;
        total++; if (done !== 3'b000) $display("FAIL reset_done got=%b exp=000", done); else passed++;
        total++; if ({sram_en, sram_wen, err} !== 3'b000)
            $display("FAIL reset_ctl got=%b exp=000", {sram_en, sram_wen, err}); else passed++;
        total++; if (rdata !== '0 || sram_addr !== '0 || sram_wdata !== '0)
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp=0", rdata, sram_addr, sram_wdata);
        else passed++;
    endtask

    task automatic test_single_read();
        req = 3'b001; wen = 3'b000; addr = {7'd0, 7'd0, 7'd5};
        tick();
        req = 3'b000;
        total++; if (gnt !== 3'b001 || sram_en !== 1'b1 || sram_wen !== 1'b0)
            $display("FAIL read_grant got gnt=%b en=%b wen=%b exp gnt=001 en=1 wen=0", gnt, sram_en, sram_wen);
        else passed++;
        total++; if (sram_addr !== 7'd5) $display("FAIL read_addr got=%0d exp=5", sram_addr); else passed++;
        tick();
        total++; if (done !== 3'b000 || gnt !== 3'b001)
            $display("FAIL read_wait got done=%b gnt=%b exp done=000 gnt=001", done, gnt); else passed++;
        sram_ack = 1'b1; sram_rdata = 71'h1ABC;
        tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b001 || gnt !== 3'b000 || sram_en !== 1'b0)
            $display("FAIL read_done got done=%b gnt=%b en=%b exp done=001 gnt=000 en=0", done, gnt, sram_en);
        else passed++;
        total++; if (rdata !== 71'h1ABC) $display("FAIL read_rdata got=%h exp=1abc", rdata); else passed++;
        tick();
        total++; if (done !== 3'b000) $display("FAIL read_done_pulse got=%b exp=000", done); else passed++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        do_reset();
        req = 3'b111; wen = 3'b000; sram_rdata = 71'h777;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (gnt !== exp_g[i]) $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, exp_g[i]); else passed++;
            sram_ack = 1'b1;
            tick();
            sram_ack = 1'b0;
            total++; if (done !== exp_g[i] || gnt !== 3'b000)
                $display("FAIL rr_done%0d got done=%b gnt=%b exp done=%b gnt=000", i, done, gnt, exp_g[i]);
            else passed++;
            tick();
            total++; if (gnt !== 3'b000 || done !== 3'b000)
                $display("FAIL rr_release%0d got gnt=%b done=%b exp 000/000", i, gnt, done); else passed++;
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_write_hold();
        // Pointer is 1 after the round-robin sequence ended on requester 0.
        req = 3'b010; wen = 3'b010; addr = {7'd0, 7'd9, 7'd0};
        wdata = {71'd0, 71'h55, 71'd0};
        tick();
        total++; if (gnt !== 3'b010 || sram_wen !== 1'b1)
            $display("FAIL wr_grant got gnt=%b wen=%b exp gnt=010 wen=1", gnt, sram_wen); else passed++;
        req = 3'b000; addr = {3{7'h7F}}; wdata = {3{71'h2AA}};
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (sram_addr !== 7'd9 || sram_wdata !== 71'h55 || sram_en !== 1'b1)
                $display("FAIL wr_hold%0d got addr=%0d wdata=%h en=%b exp addr=9 wdata=55 en=1",
                         i, sram_addr, sram_wdata, sram_en);
            else passed++;
        end
        sram_ack = 1'b1; sram_rdata = 71'h999;
        tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b010) $display("FAIL wr_done got=%b exp=010", done); else passed++;
        total++; if (rdata !== 71'h777) $display("FAIL wr_rdata got=%h exp=777", rdata); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        // Pointer is 2; only requester 0 asks, so it wins.
        req = 3'b001; wen = 3'b000;
        tick();
        req = 3'b000;
        total++; if (gnt !== 3'b001) $display("FAIL to_grant got=%b exp=001", gnt); else passed++;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        total++; if (err !== 1'b0 || gnt !== 3'b001 || done !== 3'b000)
            $display("FAIL to_early got err=%b gnt=%b done=%b exp err=0 gnt=001 done=000", err, gnt, done);
        else passed++;
        tick();
        total++; if (err !== 1'b1 || done !== 3'b001 || gnt !== 3'b000)
            $display("FAIL to_fire got err=%b done=%b gnt=%b exp err=1 done=001 gnt=000", err, done, gnt);
        else passed++;
        total++; if (rdata !== 71'h777) $display("FAIL to_rdata got=%h exp=777", rdata); else passed++;
        tick();
        // Pointer advanced past requester 0; requester 2 is served next.
        req = 3'b100; sram_rdata = 71'h123;
        tick();
        req = 3'b000;
        total++; if (gnt !== 3'b100) $display("FAIL to_next_grant got=%b exp=100", gnt); else passed++;
        sram_ack = 1'b1;
        tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b100 || rdata !== 71'h123 || err !== 1'b1)
            $display("FAIL to_next_done got done=%b rdata=%h err=%b exp done=100 rdata=123 err=1", done, rdata, err);
        else passed++;
        tick();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        req = 3'b001; wen = 3'b000; sram_rdata = 71'h4242;
        tick();
        req = 3'b000;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        sram_ack = 1'b1;
        tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b001 || err !== 1'b0 || rdata !== 71'h4242)
            $display("FAIL ack_at_to got done=%b err=%b rdata=%h exp done=001 err=0 rdata=4242", done, err, rdata);
        else passed++;
        tick();
    endtask

    task automatic test_idle_ack();
        sram_ack = 1'b1; sram_rdata = 71'h5A5A;
        tick(); tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b000 || gnt !== 3'b000 || rdata !== 71'h4242)
            $display("FAIL idle_ack got done=%b gnt=%b rdata=%h exp 000/000/4242", done, gnt, rdata);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        // Pointer is 1 here; requester 2 is granted so reset has state to clear.
        req = 3'b100; wen = 3'b000; addr = {7'd5, 7'd0, 7'd0};
        tick();
        req = 3'b000;
        tick();
        total++; if (gnt !== 3'b100 || sram_addr !== 7'd5)
            $display("FAIL mid_busy got gnt=%b addr=%0d exp gnt=100 addr=5", gnt, sram_addr); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (gnt !== 3'b000 || done !== 3'b000 || sram_en !== 1'b0 || sram_addr !== '0 || rdata !== '0)
            $display("FAIL mid_reset got gnt=%b done=%b en=%b addr=%0d rdata=%h exp all 0",
                     gnt, done, sram_en, sram_addr, rdata);
        else passed++;
        sram_ack = 1'b1;
        tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b000) $display("FAIL mid_no_done got=%b exp=000", done); else passed++;
        req = 3'b110;
        tick();
        req = 3'b000;
        total++; if (gnt !== 3'b010) $display("FAIL mid_ptr got=%b exp=010", gnt); else passed++;
        sram_ack = 1'b1;
        tick();
        sram_ack = 1'b0;
        total++; if (done !== 3'b010) $display("FAIL mid_done got=%b exp=010", done); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_timeout();
        test_ack_at_timeout();
        test_idle_ack();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/t05_sram_arbiter.md
T05_SRAM_ARBITER -- requirements
Module: t05_sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SRAM word address width (node index space).
REQ-002 Parameter DATA_W, default 71, SRAM word width (one tree/null node).
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for sram_ack before error.
REQ-004 Reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req  in  3  per-requester access request; [0]=hTree, [1]=FLV, [2]=codebook.
REQ-008 wen  in  3  per-requester 1=write, 0=read; sampled with req.
REQ-009 addr  in  3*ADDR_W  per-requester address, slice i = requester i.
REQ-010 wdata  in  3*DATA_W  per-requester write data, slice i = requester i.
REQ-011 gnt  out  3  one-hot grant, high while requester owns the SRAM port.
REQ-012 done  out  3  one-cycle pulse, requester's transaction complete.
REQ-013 rdata  out  DATA_W  read data captured from SRAM, valid with done.
REQ-014 sram_en  out  1  access strobe to SRAM wrapper.
REQ-015 sram_wen  out  1  1=write, 0=read to SRAM wrapper.
REQ-016 sram_addr  out  ADDR_W  latched address of winning requester.
REQ-017 sram_wdata  out  DATA_W  latched write data of winning requester.
REQ-018 sram_rdata  in  DATA_W  SRAM read data, valid when sram_ack high.
REQ-019 sram_ack  in  1  SRAM wrapper completion, one-cycle pulse.
REQ-020 err  out  1  sticky timeout flag for controller (maps to op_fin error code).

Function
REQ-021 FSM states IDLE, BUSY, RELEASE; all outputs registered.
REQ-022 IDLE, req!=0: winner = first set req bit scanning ptr, ptr+1, ptr+2 (mod 3); latch wen/addr/wdata of winner; gnt one-hot winner, sram_en=1 next cycle; -> BUSY.
REQ-023 IDLE, req==0: stay IDLE, gnt=0, sram_en=0.
REQ-024 BUSY: sram_en, sram_wen, sram_addr, sram_wdata held constant until sram_ack; req/addr/wdata changes ignored.
REQ-025 BUSY, sram_ack=1: next cycle done[winner]=1, rdata<=sram_rdata if read (unchanged on write), gnt=0, sram_en=0, ptr<=(winner+1) mod 3; -> RELEASE.
REQ-026 RELEASE: single cycle, no grant, no strobe; -> IDLE. Minimum spacing between grants = 3 cycles.
REQ-027 Latency: req seen in IDLE at cycle N -> gnt/sram_en at N+1; sram_ack at M -> done at M+1.
REQ-028 Timeout counter: cleared entering BUSY, increments each BUSY cycle without ack; reaching TIMEOUT -> err<=1, done[winner] pulsed, rdata unchanged, -> RELEASE.
REQ-029 sram_ack and timeout in same cycle: ack wins, err not set.
REQ-030 Requester dropping req during BUSY: transaction completes, done still pulsed.
REQ-031 sram_ack outside BUSY: ignored, no output change.
REQ-032 err sticky until rst; arbitration continues normally after err.
REQ-033 gnt, done always one-hot or zero; done never overlaps gnt.

Reset
REQ-034 rst=1 at any edge, including mid-BUSY: state=IDLE, ptr=0, counter=0, gnt=0, done=0, rdata=0, sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, err=0; in-flight transaction abandoned, no done.

Verification
REQ-035 Single read: req=3'b001, wen=0, addr0=7'd5; ack 2 cycles after sram_en with rdata=71'h1ABC -> gnt=001, sram_addr=5, done=001 and rdata=71'h1ABC one cycle after ack.
REQ-036 Round-robin: req=3'b111 held, ack each access after 1 cycle -> grant order 001,010,100,001; each gnt separated by RELEASE cycle.
REQ-037 Write hold: req[1] write addr=7'd9 wdata=71'h55, change addr1/wdata1 during BUSY -> sram_addr=9, sram_wdata=71'h55 stable until ack; rdata unchanged.
REQ-038 Timeout: never ack -> after 255 BUSY cycles err=1, done pulsed for winner; next request proceeds normally, err stays 1.
REQ-039 Reset mid-op: assert rst in BUSY -> next cycle all outputs 0, no done; subsequent req=3'b110 grants requester 1 first (ptr=0).
REQ-040 Ack at timeout cycle: ack on the 255th BUSY cycle -> done pulsed, err=0.
